s_ctrl_ring: RTL and testbench
==============================

# s_ctrl_ring

Compute-sequencing controller for an NSLOT-deep ring of source buffers. It generalises the two-slot ping-pong start/finish handshake to any power-of-two slot count. It tracks which slots hold filled source batches and issues one compute-start pulse per batch, in order. It releases each finished result to the destination buffer only when the destination is ready and either the next batch is already present or the finished batch was the last. It sits between the source DMA receiver, the compute core and the destination buffer.

## Interface
Parameters:
- NSLOT, 2, number of source buffer slots; power of two, ≥2
- PW, $clog2(NSLOT), slot index width (derived, not overridden)

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  reset, synchronous, active-high
- run  in  1  enable; when low, the block behaves exactly as under rst
- src_fin  in  1  one-cycle pulse: the source finished filling slot src_slot
- src_last  in  1  qualifies src_fin: the batch just written is the final one
- s_fin  in  1  one-cycle pulse from the compute core: the current batch's results are in the output register file
- dst_ready  in  1  destination buffer can accept a result set this cycle
- src_ready  out  1  a free slot exists; the source may write src_slot
- src_slot  out  PW  slot the next src_fin fills (write pointer)
- s_init  out  1  registered one-cycle pulse: start compute on slot s_slot
- s_slot  out  PW  slot being computed (read pointer)
- s_fin_in  out  1  combinational commit: transfer results to dst, free s_slot
- count  out  PW+1  number of filled slots, 0..NSLOT
- busy  out  1  state is RUN or HOLD
- done  out  1  sticky: the last batch has been committed
- err  out  1  sticky: src_fin arrived while src_ready was 0

## Operation
- State per slot: last_q[NSLOT], written on each accepted src_fin.
- Pointers: wr_ptr (src_slot) and rd_ptr (s_slot), both modulo NSLOT.
- Accept: src_fin & src_ready. Effects: last_q[wr_ptr] <= src_last; wr_ptr++; count++.
- src_ready = (count < NSLOT) & (state != DONE), using registered count.
- src_fin when src_ready=0:
  - no pointer or count change.
  - err <= 1.
  - src_fin in DONE also sets err.
- Commit condition (uses registered count): s_fin_in = (s_fin & state==RUN | state==HOLD) & dst_ready & (count ≥ 2 | last_q[rd_ptr]).
- Commit effects: rd_ptr++; count--. If last_q[rd_ptr], go to DONE; otherwise go to RUN and pulse s_init the next cycle.
- The slot is freed at commit, not at s_init, because compute reads the source slot for the whole batch.
- States:
  - IDLE:
    - if count > 0, or an accepted src_fin this cycle: s_init <= 1 and go to RUN.
    - otherwise stay in IDLE.
  - RUN:
    - on s_fin with commit: commit.
    - on s_fin without commit: go to HOLD.
    - otherwise wait.
  - HOLD: re-evaluate the commit condition every cycle; stay until it holds.
  - DONE:
    - done=1, src_ready=0, s_init never pulses.
    - leave only via rst or run low.
- s_fin outside RUN is ignored: no state change, no s_fin_in.
- Simultaneous accepted src_fin and commit: count unchanged; both pointers advance.
- count arithmetic is unsigned PW+1 bits and never wraps. Pointers wrap from NSLOT-1 to 0.

## Timing
- Reset / run low, next edge: state=IDLE, pointers=0, count=0, last_q=0, s_init=0, done=0, err=0.
- After reset, src_ready=1 combinationally (count=0), all other outputs 0.
- src_fin accepted at cycle t in IDLE: s_init=1 at t+1, s_slot=0.
- Commit at cycle c, not last: s_init=1 at c+1, s_slot already advanced.
- Back-to-back throughput: one batch per compute duration + 1 cycle.
- s_fin_in is same-cycle combinational with s_fin/dst_ready, with zero latency. It is high for exactly one cycle per batch.
- s_init is exactly one cycle wide and never asserts while busy=1 in the same cycle as s_fin_in.
- run low or rst mid-batch: abort. All state clears at the next edge and any pending HOLD is dropped without s_fin_in.

## Test plan
- Single batch, NSLOT=2: src_fin+src_last at t0 -> s_init at t1, s_slot=0. s_fin at t6 with dst_ready=1 -> s_fin_in at t6, done=1 at t7, no further s_init.
- Ping-pong, 3 batches (last on the third): -> s_slot sequence 0,1,0. The first s_fin while count=1 -> HOLD, no s_fin_in. The second src_fin arrives -> s_fin_in the next cycle, s_init the cycle after.
- Backpressure: s_fin with count=2 and dst_ready=0 for 4 cycles -> s_fin_in=0 for those cycles, then 1 in the first cycle dst_ready=1. count goes 2→1.
- Full ring, NSLOT=4: 4 src_fin with no s_fin -> count=4, src_ready=0. A fifth src_fin -> err=1, count stays 4, src_slot stays 0.
- Simultaneous: accepted src_fin in the same cycle as a commit -> count unchanged, src_slot and s_slot both +1.
- Abort: run low during RUN with count=3 -> next cycle state IDLE, count=0, busy=0, no s_fin_in even if s_fin pulses.

Source files
------------

// File: rtl/s_ctrl_ring.sv
// s_ctrl_ring: compute-sequencing controller for an NSLOT-deep ring of
// source buffers. Tracks filled slots, starts compute on each batch in
// order, and releases finished results to the destination only when the
// next batch is already present or the finished batch was the last one.
module s_ctrl_ring #(
  parameter int NSLOT = 2,
  localparam int PW = $clog2(NSLOT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          src_fin,
  input  logic          src_last,
  input  logic          s_fin,
  input  logic          dst_ready,
  output logic          src_ready,
  output logic [PW-1:0] src_slot,
  output logic          s_init,
  output logic [PW-1:0] s_slot,
  output logic          s_fin_in,
  output logic [PW:0]   count,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

  localparam logic [PW:0] FULL = (PW+1)'(NSLOT);
  localparam logic [PW:0] TWO  = (PW+1)'(2);

  state_t           state_q, state_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic [NSLOT-1:0] last_q, last_d;
  logic             s_init_q, s_init_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // rst and run low are the same synchronous clear
  logic clr;
  logic accept;
  logic commit_ok;
  logic commit;

  assign clr = rst | ~run;

  // Per-slot "last batch" flag, captured when the source finishes that slot
  for (genvar gi = 0; gi < NSLOT; gi++) begin : g_last
    always_comb begin
      last_d[gi] = last_q[gi];
      if (accept && (wr_ptr_q == PW'(gi))) begin
        last_d[gi] = src_last;
      end
    end
  end

  // Handshake decode, pointer/count arithmetic and the sequencing FSM
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    s_init_d  = 1'b0;
    done_d    = done_q;
    err_d     = err_q;

    src_ready = (count_q < FULL) && (state_q != DONE);
    accept    = src_fin && src_ready;
    // Results may only leave once the next batch is present (so compute
    // can restart immediately) or when nothing follows this batch.
    commit_ok = dst_ready && ((count_q >= TWO) || last_q[rd_ptr_q]);
    // An abort in progress must never release a result
    commit    = !clr && commit_ok &&
                ((s_fin && (state_q == RUN)) || (state_q == HOLD));

    if (src_fin && !src_ready) begin
      err_d = 1'b1;
    end
    if (accept) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    // The slot is freed at commit: compute reads it for the whole batch
    if (commit) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    case ({accept, commit})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if ((count_q != '0) || accept) begin
          s_init_d = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (s_fin && !commit) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        state_d = HOLD;
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Shared commit exit from RUN and HOLD
    if (commit) begin
      if (last_q[rd_ptr_q]) begin
        state_d = DONE;
        done_d  = 1'b1;
      end else begin
        state_d  = RUN;
        s_init_d = 1'b1;
      end
    end
  end

  // State register with synchronous clear
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
      s_init_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
      s_init_q <= s_init_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign src_slot = wr_ptr_q;
  assign s_slot   = rd_ptr_q;
  assign s_init   = s_init_q;
  assign s_fin_in = commit;
  assign count    = count_q;
  assign busy     = (state_q == RUN) || (state_q == HOLD);
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_s_ctrl_ring.sv
// Directed bench for s_ctrl_ring: a 2-slot and a 4-slot instance share the
// same stimulus; each scenario checks the instance it was written for.
module tb_s_ctrl_ring;

  logic clk = 1'b0;
  logic rst, run, src_fin, src_last, s_fin, dst_ready;

  logic       a_src_ready, a_s_init, a_s_fin_in, a_busy, a_done, a_err;
  logic [0:0] a_src_slot, a_s_slot;
  logic [1:0] a_count;

  logic       b_src_ready, b_s_init, b_s_fin_in, b_busy, b_done, b_err;
  logic [1:0] b_src_slot, b_s_slot;
  logic [2:0] b_count;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  s_ctrl_ring #(.NSLOT(2)) u_a (
    .clk(clk), .rst(rst), .run(run), .src_fin(src_fin), .src_last(src_last),
    .s_fin(s_fin), .dst_ready(dst_ready), .src_ready(a_src_ready),
    .src_slot(a_src_slot), .s_init(a_s_init), .s_slot(a_s_slot),
    .s_fin_in(a_s_fin_in), .count(a_count), .busy(a_busy), .done(a_done),
    .err(a_err)
  );

  s_ctrl_ring #(.NSLOT(4)) u_b (
    .clk(clk), .rst(rst), .run(run), .src_fin(src_fin), .src_last(src_last),
    .s_fin(s_fin), .dst_ready(dst_ready), .src_ready(b_src_ready),
    .src_slot(b_src_slot), .s_init(b_s_init), .s_slot(b_s_slot),
    .s_fin_in(b_s_fin_in), .count(b_count), .busy(b_busy), .done(b_done),
    .err(b_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one edge, sample just after it, and drop the one-cycle pulses
  task automatic step();
    @(posedge clk);
    #1;
    src_fin  = 1'b0;
    src_last = 1'b0;
    s_fin    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; run = 1'b1; src_fin = 1'b0; src_last = 1'b0;
    s_fin = 1'b0; dst_ready = 1'b1;
    do_reset();

    // Reset state
    chk("rst_src_ready", a_src_ready, 1);
    chk("rst_src_slot",  a_src_slot, 0);
    chk("rst_s_init",    a_s_init, 0);
    chk("rst_count",     a_count, 0);
    chk("rst_busy",      a_busy, 0);
    chk("rst_done",      a_done, 0);
    chk("rst_err",       b_err, 0);
    chk("rst_s_fin_in",  a_s_fin_in, 0);

    // Single batch, NSLOT=2
    src_fin = 1'b1; src_last = 1'b1;
    step();
    chk("single_s_init_t1", a_s_init, 1);
    chk("single_s_slot_t1", a_s_slot, 0);
    chk("single_busy_t1",   a_busy, 1);
    chk("single_count_t1",  a_count, 1);
    step();
    chk("single_s_init_t2", a_s_init, 0);
    repeat (4) step();
    s_fin = 1'b1;
    #1;
    chk("single_s_fin_in_t6", a_s_fin_in, 1);
    step();
    chk("single_done_t7",      a_done, 1);
    chk("single_busy_t7",      a_busy, 0);
    chk("single_count_t7",     a_count, 0);
    chk("single_src_ready_t7", a_src_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("single_no_s_init", a_s_init, 0);
    end
    // run low clears the sticky done
    run = 1'b0;
    step();
    run = 1'b1;
    chk("runlow_done_clear", a_done, 0);
    chk("runlow_src_ready",  a_src_ready, 1);

    // Ping-pong, three batches, NSLOT=2
    do_reset();
    src_fin = 1'b1;
    step();
    chk("pp_s_init_1",   a_s_init, 1);
    chk("pp_s_slot_1",   a_s_slot, 0);
    chk("pp_src_slot_1", a_src_slot, 1);
    step();
    s_fin = 1'b1;
    #1;
    chk("pp_hold_no_commit", a_s_fin_in, 0);
    step();
    chk("pp_hold_busy",     a_busy, 1);
    chk("pp_hold_s_fin_in", a_s_fin_in, 0);
    src_fin = 1'b1;
    #1;
    chk("pp_hold_same_cycle", a_s_fin_in, 0);
    step();
    chk("pp_count_2",       a_count, 2);
    chk("pp_commit_1",      a_s_fin_in, 1);
    step();
    chk("pp_s_init_2",  a_s_init, 1);
    chk("pp_s_slot_2",  a_s_slot, 1);
    chk("pp_count_2b",  a_count, 1);
    src_fin = 1'b1; src_last = 1'b1;
    step();
    chk("pp_count_3",   a_count, 2);
    chk("pp_s_init_off", a_s_init, 0);
    s_fin = 1'b1;
    #1;
    chk("pp_commit_2", a_s_fin_in, 1);
    step();
    chk("pp_s_init_3", a_s_init, 1);
    chk("pp_s_slot_3", a_s_slot, 0);
    chk("pp_count_3b", a_count, 1);
    step();
    s_fin = 1'b1;
    #1;
    chk("pp_commit_last", a_s_fin_in, 1);
    step();
    chk("pp_done",   a_done, 1);
    chk("pp_count0", a_count, 0);
    chk("pp_s_init_none", a_s_init, 0);

    // Backpressure, NSLOT=2
    do_reset();
    src_fin = 1'b1;
    step();
    src_fin = 1'b1;
    step();
    chk("bp_count_2", a_count, 2);
    dst_ready = 1'b0;
    s_fin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_blocked", a_s_fin_in, 0);
      step();
    end
    chk("bp_count_held", a_count, 2);
    dst_ready = 1'b1;
    #1;
    chk("bp_release", a_s_fin_in, 1);
    step();
    chk("bp_count_1",  a_count, 1);
    chk("bp_s_init",   a_s_init, 1);
    chk("bp_s_slot",   a_s_slot, 1);

    // Full ring, NSLOT=4
    do_reset();
    for (int i = 0; i < 4; i++) begin
      src_fin = 1'b1;
      step();
    end
    chk("full_count",     b_count, 4);
    chk("full_src_ready", b_src_ready, 0);
    chk("full_src_slot",  b_src_slot, 0);
    chk("full_err_pre",   b_err, 0);
    src_fin = 1'b1;
    step();
    chk("full_err",        b_err, 1);
    chk("full_count_kept", b_count, 4);
    chk("full_slot_kept",  b_src_slot, 0);

    // Simultaneous accept and commit, NSLOT=4
    do_reset();
    src_fin = 1'b1;
    step();
    src_fin = 1'b1;
    step();
    chk("sim_count_pre", b_count, 2);
    chk("sim_wr_pre",    b_src_slot, 2);
    src_fin = 1'b1; s_fin = 1'b1;
    #1;
    chk("sim_commit", b_s_fin_in, 1);
    step();
    chk("sim_count",    b_count, 2);
    chk("sim_src_slot", b_src_slot, 3);
    chk("sim_s_slot",   b_s_slot, 1);
    chk("sim_s_init",   b_s_init, 1);

    // Abort with count=3, NSLOT=4
    src_fin = 1'b1;
    step();
    chk("abort_count_pre", b_count, 3);
    chk("abort_busy_pre",  b_busy, 1);
    run = 1'b0;
    step();
    run = 1'b1;
    chk("abort_count",    b_count, 0);
    chk("abort_busy",     b_busy, 0);
    chk("abort_s_slot",   b_s_slot, 0);
    chk("abort_src_slot", b_src_slot, 0);
    s_fin = 1'b1;
    #1;
    chk("abort_no_commit", b_s_fin_in, 0);
    step();
    chk("abort_idle", b_busy, 0);
    chk("abort_no_s_init", b_s_init, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
